// File: rtl/cla_seq_pkg.sv
// Shared constants for the byte-serial CLA adder.
// Holds the slice width and the sequencer state encoding.
package cla_seq_pkg;

  localparam int BYTE_W = 8;

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_RUN  = 1'b1;

  typedef enum logic {
    S_IDLE = ST_IDLE,
    S_RUN  = ST_RUN
  } state_e;

endpackage

// File: rtl/cla_8.sv
// 8-bit carry-lookahead adder slice.
// Each carry is a flat sum of generate/propagate products.
module cla_8
  import cla_seq_pkg::*;
(
  input  logic [BYTE_W-1:0] A,
  input  logic [BYTE_W-1:0] B,
  input  logic              Cin,
  output logic [BYTE_W-1:0] Sum,
  output logic              Cout
);

  logic [BYTE_W-1:0] w_g;
  logic [BYTE_W-1:0] w_p;
  logic [BYTE_W:0]   w_c;

  // Lookahead carries: c[i+1] = g[i] | p[i]g[i-1] | ... | p[i..0]cin
  function automatic logic [BYTE_W:0] carries(
    input logic [BYTE_W-1:0] g,
    input logic [BYTE_W-1:0] p,
    input logic              ci
  );
    logic [BYTE_W:0] c;
    logic            pr;
    c    = '0;
    c[0] = ci;
    for (int i = 0; i < BYTE_W; i++) begin
      c[i+1] = g[i];
      pr     = p[i];
      for (int j = i - 1; j >= 0; j--) begin
        c[i+1] = c[i+1] | (pr & g[j]);
        pr     = pr & p[j];
      end
      c[i+1] = c[i+1] | (pr & ci);
    end
    return c;
  endfunction

  assign w_g  = A & B;
  assign w_p  = A ^ B;
  assign w_c  = carries(w_g, w_p, Cin);
  assign Sum  = w_p ^ w_c[BYTE_W-1:0];
  assign Cout = w_c[BYTE_W];

endmodule

// File: rtl/cla_seq_adder_ctrl.sv
// Byte-serial wide adder reusing one cla_8 slice.
// One byte per clock, LSB first, carry chained through a register.
module cla_seq_adder_ctrl
  import cla_seq_pkg::*;
#(
  parameter  int NBYTES = 4,
  localparam int W      = BYTE_W * NBYTES
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] sum,
  output logic         cout
);

  localparam int IDXW = $clog2(NBYTES);

  state_e r_state;
  state_e w_state_nxt;

  logic [W-1:0]      r_a;
  logic [W-1:0]      r_b;
  logic              r_carry;
  logic [IDXW-1:0]   r_idx;

  logic              w_accept;
  logic              w_last;
  logic [BYTE_W-1:0] w_a_byte;
  logic [BYTE_W-1:0] w_b_byte;
  logic [BYTE_W-1:0] w_sum;
  logic              w_cout;

  assign w_last   = (r_idx == IDXW'(NBYTES - 1));
  assign w_a_byte = r_a[BYTE_W*r_idx +: BYTE_W];
  assign w_b_byte = r_b[BYTE_W*r_idx +: BYTE_W];
  assign busy     = (r_state == S_RUN);

  cla_8 u_cla (
    .A    (w_a_byte),
    .B    (w_b_byte),
    .Cin  (r_carry),
    .Sum  (w_sum),
    .Cout (w_cout)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next state; a start is only taken while idle
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_RUN;
          w_accept    = 1'b1;
        end
      end
      S_RUN: begin
        if (w_last) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Operand capture, per-byte result write and done pulse
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_carry <= 1'b0;
      r_idx   <= '0;
      sum     <= '0;
      cout    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (w_accept) begin
        r_a     <= a;
        r_b     <= b;
        r_carry <= cin;
        r_idx   <= '0;
        sum     <= '0;
        cout    <= 1'b0;
      end else if (r_state == S_RUN) begin
        sum[BYTE_W*r_idx +: BYTE_W] <= w_sum;
        r_carry <= w_cout;
        if (w_last) begin
          r_idx <= '0;
          cout  <= w_cout;
          done  <= 1'b1;
        end else begin
          r_idx <= r_idx + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_cla_seq_adder_ctrl.sv
// Self-checking bench for cla_seq_adder_ctrl (NBYTES=4).
// Results are checked against plain a+b+cin arithmetic.
module tb_cla_seq_adder_ctrl;

  localparam int NB = 4;
  localparam int W  = 8 * NB;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  cla_seq_adder_ctrl #(.NBYTES(NB)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  function automatic logic [W:0] model(
    input logic [W-1:0] x,
    input logic [W-1:0] y,
    input logic         ci
  );
    return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
  endfunction

  // one rising edge, then settle away from it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // issue one start pulse; returns edges until done seen (0 = timeout)
  task automatic run_op(
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  logic         ci,
    output int           lat
  );
    a = x; b = y; cin = ci; start = 1'b1;
    tick();
    start = 1'b0;
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (done) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    tick(); tick();
    n_tests++;
    if ({busy, done, sum, cout} !== '0) begin
      n_fail++;
      $display("FAIL reset: busy=%b done=%b sum=%h cout=%b want all 0",
               busy, done, sum, cout);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    int lat;
    run_op(32'h000000FF, 32'h00000001, 1'b0, lat);
    n_tests++;
    if (lat != NB) begin
      n_fail++;
      $display("FAIL basic_latency: got %0d want %0d", lat, NB);
    end
    n_tests++;
    if ({cout, sum} !== {1'b0, 32'h00000100}) begin
      n_fail++;
      $display("FAIL basic_sum: got %b_%h want 0_00000100", cout, sum);
    end
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_busy_in_done: got %b want 0", busy);
    end
    tick();
    n_tests++;
    if (done !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_done_pulse: done=%b want 0 after one cycle", done);
    end
  endtask

  task automatic test_carry_chain();
    int lat;
    run_op(32'hFFFFFFFF, 32'h0, 1'b1, lat);
    n_tests++;
    if (lat != NB || {cout, sum} !== {1'b1, 32'h0}) begin
      n_fail++;
      $display("FAIL carry_chain: lat=%0d got %b_%h want lat 4 1_00000000",
               lat, cout, sum);
    end
  endtask

  task automatic test_ignore_busy();
    int dones = 0;
    int first = 0;
    a = 32'h12345678; b = 32'h11111111; cin = 1'b0; start = 1'b1;
    tick();
    for (int i = 1; i <= NB + 8; i++) begin
      if (i < NB) begin
        a = $urandom; b = $urandom; cin = 1'($urandom); start = 1'b1;
      end else begin
        start = 1'b0;
      end
      tick();
      if (done) begin
        dones++;
        if (first == 0) begin
          first = i;
          n_tests++;
          if ({cout, sum} !== {1'b0, 32'h23456789}) begin
            n_fail++;
            $display("FAIL ignore_busy_sum: got %b_%h want 0_23456789",
                     cout, sum);
          end
        end
      end
    end
    n_tests++;
    if (dones != 1 || first != NB) begin
      n_fail++;
      $display("FAIL ignore_busy_pulses: got %0d at %0d want 1 at %0d",
               dones, first, NB);
    end
  endtask

  task automatic test_mid_reset();
    int dones = 0;
    int lat;
    a = 32'hFFFF_FFFF; b = 32'h0000_0001; cin = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    n_tests++;
    if ({busy, done, sum, cout} !== '0) begin
      n_fail++;
      $display("FAIL mid_reset: busy=%b done=%b sum=%h cout=%b want all 0",
               busy, done, sum, cout);
    end
    for (int i = 0; i < 8; i++) begin
      tick();
      if (done || busy) dones++;
    end
    n_tests++;
    if (dones != 0) begin
      n_fail++;
      $display("FAIL mid_reset_quiet: got %0d active cycles want 0", dones);
    end
    run_op(32'd5, 32'd6, 1'b0, lat);
    n_tests++;
    if (lat != NB || {cout, sum} !== {1'b0, 32'd11}) begin
      n_fail++;
      $display("FAIL mid_reset_next: lat=%0d got %b_%h want lat 4 0_0000000b",
               lat, cout, sum);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    run_op(32'h000000FF, 32'h00000001, 1'b0, lat);
    n_tests++;
    if (lat != NB || {cout, sum} !== {1'b0, 32'h00000100}) begin
      n_fail++;
      $display("FAIL b2b_first: lat=%0d got %b_%h want lat 4 0_00000100",
               lat, cout, sum);
    end
    run_op(32'h80000000, 32'h80000000, 1'b0, lat);
    n_tests++;
    if (lat != NB || {cout, sum} !== {1'b1, 32'h0}) begin
      n_fail++;
      $display("FAIL b2b_second: lat=%0d got %b_%h want lat 4 1_00000000",
               lat, cout, sum);
    end
  endtask

  task automatic test_random();
    int errs = 0;
    int ovl  = 0;
    logic [W-1:0] x, y;
    logic         ci;
    logic [W:0]   exp;
    int           lat;
    for (int k = 0; k < 1000; k++) begin
      x  = $urandom;
      y  = $urandom;
      ci = 1'($urandom);
      case ($urandom_range(0, 3))
        0: begin x = '1; ci = 1'b1; end
        1: y = ~x;
        default: ;
      endcase
      exp = model(x, y, ci);
      a = x; b = y; cin = ci; start = 1'b1;
      tick();
      start = 1'b0;
      lat = 0;
      for (int i = 1; i <= 20; i++) begin
        a = $urandom; b = $urandom; cin = 1'($urandom);
        tick();
        if (busy && done) ovl++;
        if (done) begin
          lat = i;
          break;
        end
      end
      if (lat != NB || {cout, sum} !== exp) begin
        errs++;
        if (errs <= 5)
          $display("FAIL random_op%0d: lat=%0d got %b_%h want lat 4 %b_%h",
                   k, lat, cout, sum, exp[W], exp[W-1:0]);
      end
      if ($urandom_range(0, 3) == 0) tick();
    end
    n_tests++;
    if (errs != 0) begin
      n_fail++;
      $display("FAIL random_results: got %0d bad ops want 0", errs);
    end
    n_tests++;
    if (ovl != 0) begin
      n_fail++;
      $display("FAIL random_busy_done: got %0d overlaps want 0", ovl);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_carry_chain();
    test_ignore_busy();
    test_mid_reset();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
